// File: rtl/hub75_capture_if.sv
// Bus port bundle for hub75_capture: byte-addressed read/write strobes with a one-cycle
// registered response and a combinational address-decode hit.
interface hub75_capture_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    logic        ren;
    logic [31:0] rdata;
    logic        ready;
    logic        active;

    modport master (
        output addr, wdata, wmask, wen, ren,
        input  rdata, ready, active
    );

    modport slave (
        input  addr, wdata, wmask, wen, ren,
        output rdata, ready, active
    );
endinterface

// File: rtl/hub75_capture.sv
// HUB75 panel sniffer: double-buffered line capture copied row-by-row into a bus-readable frame RAM.
// Optional macro HUB75_CAPTURE_STATS_EN adds a latch/frame counter word. COLS must be a power of two.
module hub75_capture #(
    parameter int unsigned ROWS     = 64,
    parameter int unsigned COLS     = 64,
    parameter logic [31:0] BASEADDR = 32'h8200_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    hub75_capture_if.slave            bus,
    input  logic                      R0,
    input  logic                      G0,
    input  logic                      B0,
    input  logic                      R1,
    input  logic                      G1,
    input  logic                      B1,
    input  logic [$clog2(ROWS/2)-1:0] ROWSEL,
    input  logic                      CLK_HUB75,
    input  logic                      LATCH,
    input  logic                      OE
);
    localparam int unsigned NumRows = ROWS / 2;
    localparam int unsigned Pixels  = NumRows * COLS;
    localparam int unsigned RowW    = $clog2(NumRows);
    localparam int unsigned IdxW    = $clog2(COLS);
    localparam int unsigned CntW    = $clog2(COLS + 1);
    localparam int unsigned FaW     = $clog2(Pixels);
    localparam int unsigned SyncW   = 6 + RowW + 3;
`ifdef HUB75_CAPTURE_STATS_EN
    localparam int unsigned NumWords = Pixels + 2;
`else
    localparam int unsigned NumWords = Pixels + 1;
`endif

    typedef enum logic [0:0] {StIdle, StCopy} state_e;

    // Input synchronizer and edge history
    logic [SyncW-1:0] sync1_q, sync2_q;
    logic             hclk_prev_q, latch_prev_q;
    logic [5:0]       s_pixel;
    logic [RowW-1:0]  s_row;
    logic             s_hclk, s_latch, s_oe;
    logic             shift_edge, latch_edge;

    assign s_pixel    = sync2_q[SyncW-1 -: 6];
    assign s_row      = sync2_q[3 +: RowW];
    assign s_hclk     = sync2_q[2];
    assign s_latch    = sync2_q[1];
    assign s_oe       = sync2_q[0];
    assign shift_edge = s_hclk & ~hclk_prev_q;
    assign latch_edge = s_latch & ~latch_prev_q;

    // Capture and copy state
    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            bank_q, bank_d;
    logic            copy_bank_q, copy_bank_d;
    logic [RowW-1:0] copy_row_q, copy_row_d;
    logic [CntW-1:0] col_cnt_q, col_cnt_d;
    logic [CntW-1:0] last_cnt_q, last_cnt_d;
    logic [RowW-1:0] last_row_q, last_row_d;
    logic            last_oe_q, last_oe_d;
    logic [2:0]      flags_q, flags_d;   // {OVERRUN, LONG, SHORT}
    logic [2:0]      flag_set, flag_clr;
    logic            rdy_q, rdy_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [5:0] line_q [2][COLS];
    logic [5:0] frame_q [Pixels];
    logic       shift_wr, copy_wr;

    assign shift_wr = shift_edge && (col_cnt_q != CntW'(COLS));
    assign copy_wr  = (state_q == StCopy) && rst_n;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bank_d      = bank_q;
        copy_bank_d = copy_bank_q;
        copy_row_d  = copy_row_q;
        col_cnt_d   = col_cnt_q;
        last_cnt_d  = last_cnt_q;
        last_row_d  = last_row_q;
        last_oe_d   = last_oe_q;
        flag_set    = '0;

        if (shift_edge) begin
            if (col_cnt_q == CntW'(COLS)) flag_set[1] = 1'b1;
            else                          col_cnt_d   = col_cnt_q + CntW'(1);
        end

        case (state_q)
            StCopy: begin
                if (idx_q == IdxW'(COLS - 1)) state_d = StIdle;
                else                          idx_d   = idx_q + IdxW'(1);
            end
            default: state_d = StIdle;
        endcase

        // Latch wins over the running copy; a same-cycle shift already landed in the old bank.
        if (latch_edge) begin
            last_cnt_d  = col_cnt_d;
            last_row_d  = s_row;
            last_oe_d   = ~s_oe;
            flag_set[0] = (col_cnt_d != CntW'(COLS));
            flag_set[2] = (state_q == StCopy);
            copy_bank_d = bank_q;
            bank_d      = ~bank_q;
            copy_row_d  = s_row;
            col_cnt_d   = '0;
            idx_d       = '0;
            state_d     = StCopy;
        end
    end

    // Bus decode
    logic [31:0] offset;
    logic [29:0] word;
    logic        access, is_frame, is_status;
    logic [31:0] status_word, stats_word, rd_word;

    assign offset     = bus.addr - BASEADDR;
    assign word       = offset[31:2];
    assign bus.active = (bus.addr >= BASEADDR) && (offset < 32'(4 * NumWords));
    assign access     = bus.active && (bus.ren || bus.wen);
    assign is_frame   = word < 30'(Pixels);
    assign is_status  = word == 30'(Pixels);
    assign flag_clr   = (access && bus.wen && is_status && bus.wmask[2]) ? bus.wdata[18:16] : 3'b0;
    assign flags_d    = (flags_q & ~flag_clr) | flag_set;

    assign status_word = {11'b0, state_q == StCopy, last_oe_q, flags_q,
                          8'(last_row_q), 8'(last_cnt_q)};

    always_comb begin
        rd_word = stats_word;
        if (is_frame)       rd_word = {26'b0, frame_q[word[FaW-1:0]]};
        else if (is_status) rd_word = status_word;
    end

    assign rdy_d     = access;
    assign rdata_d   = access ? rd_word : rdata_q;
    assign bus.ready = rdy_q;
    assign bus.rdata = rdata_q;

`ifdef HUB75_CAPTURE_STATS_EN
    logic [15:0] latch_cnt_q, latch_cnt_d, frame_cnt_q, frame_cnt_d;
    logic        stats_clr;

    assign stats_clr   = access && bus.wen && (word == 30'(Pixels + 1));
    assign latch_cnt_d = (stats_clr ? 16'd0 : latch_cnt_q) + 16'(latch_edge);
    assign frame_cnt_d = (stats_clr ? 16'd0 : frame_cnt_q)
                         + 16'(latch_edge && (s_row == RowW'(NumRows - 1)));
    assign stats_word  = {frame_cnt_q, latch_cnt_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            latch_cnt_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            latch_cnt_q <= latch_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end
`else
    assign stats_word = '0;
`endif

    logic unused_bus;
    assign unused_bus = ^{bus.wdata[31:19], bus.wdata[15:0], bus.wmask[3], bus.wmask[1:0],
                          offset[1:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            hclk_prev_q  <= 1'b0;
            latch_prev_q <= 1'b0;
            state_q      <= StIdle;
            idx_q        <= '0;
            bank_q       <= 1'b0;
            copy_bank_q  <= 1'b0;
            copy_row_q   <= '0;
            col_cnt_q    <= '0;
            last_cnt_q   <= '0;
            last_row_q   <= '0;
            last_oe_q    <= 1'b0;
            flags_q      <= '0;
            rdy_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            sync1_q      <= {B1, G1, R1, B0, G0, R0, ROWSEL, CLK_HUB75, LATCH, OE};
            sync2_q      <= sync1_q;
            hclk_prev_q  <= s_hclk;
            latch_prev_q <= s_latch;
            state_q      <= state_d;
            idx_q        <= idx_d;
            bank_q       <= bank_d;
            copy_bank_q  <= copy_bank_d;
            copy_row_q   <= copy_row_d;
            col_cnt_q    <= col_cnt_d;
            last_cnt_q   <= last_cnt_d;
            last_row_q   <= last_row_d;
            last_oe_q    <= last_oe_d;
            flags_q      <= flags_d;
            rdy_q        <= rdy_d;
            rdata_q      <= rdata_d;
        end
    end

    // Memories keep their contents across reset.
    always_ff @(posedge clk) begin
        if (shift_wr) line_q[bank_q][col_cnt_q[IdxW-1:0]] <= s_pixel;
    end

    always_ff @(posedge clk) begin
        if (copy_wr) frame_q[{copy_row_q, idx_q}] <= line_q[copy_bank_q][idx_q];
    end
endmodule

// File: tb/tb_hub75_capture.sv
// Bench for hub75_capture: directed sequences with random pixels/rows, checked against a
// line-bank/frame model; the stats word is checked when HUB75_CAPTURE_STATS_EN is defined.
`timescale 1ns/1ps
module tb_hub75_capture;
    localparam int unsigned Cols  = 64;
    localparam int unsigned NRows = 32;
    localparam int unsigned Pix   = NRows * Cols;
    localparam logic [31:0] Base    = 32'h8200_0000;
    localparam logic [31:0] StatusA = Base + 32'(4 * Pix);
    localparam logic [31:0] StatsA  = StatusA + 32'd4;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       r0 = 0, g0 = 0, b0 = 0, r1 = 0, g1 = 0, b1 = 0;
    logic [4:0] rowsel = '0;
    logic       hclk = 1'b0, latch = 1'b0, oe = 1'b1;

    hub75_capture_if bus ();

    hub75_capture #(.ROWS(64), .COLS(Cols), .BASEADDR(Base)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .R0(r0), .G0(g0), .B0(b0), .R1(r1), .G1(g1), .B1(b1),
        .ROWSEL(rowsel), .CLK_HUB75(hclk), .LATCH(latch), .OE(oe)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: two line banks, frame image, status fields, stats counts
    logic [5:0] m_bank [2][Cols];
    bit         m_bank_ok [2][Cols];
    logic [5:0] m_frame [Pix];
    bit         m_frame_ok [Pix];
    int         m_fill = 0, m_col = 0, m_last_cnt = 0, m_last_row = 0, m_pend_row = 0;
    int         m_last_latch = -1000, m_latches = 0, m_frames = 0;
    bit         m_oe = 0, m_short = 0, m_long = 0, m_ovr = 0;
    logic [31:0] d;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status(input bit busy);
        return {11'b0, busy, m_oe, m_ovr, m_long, m_short, 8'(m_last_row), 8'(m_last_cnt)};
    endfunction

    task automatic bus_access(input logic [31:0] a, input bit we, input logic [31:0] wd,
                              input logic [3:0] wm, input bit exp_rdy, output logic [31:0] q);
        bus.addr = a; bus.wdata = wd; bus.wmask = wm; bus.wen = we; bus.ren = !we;
        tick(1);
        bus.wen = 1'b0; bus.ren = 1'b0;
        chk("ready", {31'b0, bus.ready}, {31'b0, exp_rdy});
        q = bus.rdata;
        tick(1);
        chk("ready_idle", {31'b0, bus.ready}, 32'd0);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] q);
        bus_access(a, 1'b0, 32'd0, 4'h0, 1'b1, q);
    endtask

    task automatic shift_px(input logic [5:0] px);
        {b1, g1, r1, b0, g0, r0} = px;
        hclk = 1'b1; tick(2); hclk = 1'b0; tick(1);
        if (m_col < Cols) begin
            m_bank[m_fill][m_col] = px; m_bank_ok[m_fill][m_col] = 1'b1; m_col++;
        end else m_long = 1'b1;
    endtask

    task automatic do_latch(input int row, input bit oe_n);
        rowsel = 5'(row); oe = oe_n; latch = 1'b1;
        if (cyc - m_last_latch < Cols) begin
            m_ovr = 1'b1;
            for (int i = 0; i < Cols; i++) m_frame_ok[m_pend_row * Cols + i] = 1'b0;
        end
        if (m_col < Cols) m_short = 1'b1;
        m_last_cnt = m_col; m_last_row = row; m_oe = !oe_n;
        for (int i = 0; i < Cols; i++) begin
            m_frame[row * Cols + i]    = m_bank[m_fill][i];
            m_frame_ok[row * Cols + i] = m_bank_ok[m_fill][i];
        end
        m_fill ^= 1; m_col = 0; m_pend_row = row; m_last_latch = cyc;
        m_latches++;
        if (row == NRows - 1) m_frames++;
        tick(2); latch = 1'b0; tick(1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        if (cyc - m_last_latch < Cols + 8)
            for (int i = 0; i < Cols; i++) m_frame_ok[m_pend_row * Cols + i] = 1'b0;
        m_fill = 0; m_col = 0; m_last_cnt = 0; m_last_row = 0; m_oe = 0;
        m_short = 0; m_long = 0; m_ovr = 0; m_last_latch = -1000; m_latches = 0; m_frames = 0;
    endtask

    task automatic chk_row(input int row);
        logic [31:0] q;
        for (int i = 0; i < Cols; i++) begin
            int w;
            w = row * Cols + i;
            if (m_frame_ok[w]) begin
                bus_read(Base + 32'(4 * w), q);
                chk("frame", q, {26'b0, m_frame[w]});
            end
        end
    endtask

    task automatic chk_status(input bit busy);
        logic [31:0] q;
        bus_read(StatusA, q);
        chk("status", q, m_status(busy));
    endtask

    task automatic clear_flags();
        logic [31:0] q;
        bus_access(StatusA, 1'b1, 32'h0007_0000, 4'b0100, 1'b1, q);
        m_short = 0; m_long = 0; m_ovr = 0;
    endtask

    task automatic random_row(input int row, input bit oe_n);
        for (int i = 0; i < Cols; i++) shift_px(6'($urandom));
        do_latch(row, oe_n);
    endtask

    initial begin
        int ra, rb;
        bus.addr = '0; bus.wdata = '0; bus.wmask = '0; bus.wen = 1'b0; bus.ren = 1'b0;
        for (int b = 0; b < 2; b++) for (int i = 0; i < Cols; i++) m_bank_ok[b][i] = 1'b0;
        for (int i = 0; i < Pix; i++) m_frame_ok[i] = 1'b0;
        tick(3); rst_n = 1'b1;

        // Reset state and decode boundaries
        chk("reset_ready", {31'b0, bus.ready}, 32'd0);
        chk_status(1'b0);
        bus.addr = Base - 32'd4; #1;
        chk("active_below", {31'b0, bus.active}, 32'd0);
        bus.addr = StatusA; #1;
        chk("active_status", {31'b0, bus.active}, 32'd1);
        bus_access(Base - 32'd4, 1'b0, 32'd0, 4'h0, 1'b0, d);

        // Ramp row: pixel i = i
        for (int i = 0; i < Cols; i++) shift_px(6'(i));
        do_latch(5, 1'b1);
        tick(80);
        chk_row(5);
        chk_status(1'b0);

        // Writes into frame space are ignored
        bus_access(Base + 32'(4 * (5 * Cols + 3)), 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b1, d);
        bus_read(Base + 32'(4 * (5 * Cols + 3)), d);
        chk("frame_wr_ignored", d, {26'b0, m_frame[5 * Cols + 3]});

        // Random full rows
        for (int k = 0; k < 3; k++) begin
            random_row(int'($urandom_range(0, NRows - 1)), 1'($urandom));
            tick(80);
            chk_row(m_last_row);
            chk_status(1'b0);
        end

        // Short row, then flag clear
        for (int i = 0; i < 40; i++) shift_px(6'($urandom));
        do_latch(int'($urandom_range(0, NRows - 1)), 1'b0);
        tick(80);
        chk_status(1'b0);
        clear_flags();
        chk_status(1'b0);

        // Long row: extra edges dropped
        for (int i = 0; i < 70; i++) shift_px(6'($urandom));
        do_latch(int'($urandom_range(0, NRows - 1)), 1'b1);
        tick(80);
        chk_status(1'b0);
        chk_row(m_last_row);
        clear_flags();

        // Two latches 10 cycles apart
        ra = int'($urandom_range(0, 15));
        rb = int'($urandom_range(16, NRows - 1));
        for (int i = 0; i < Cols; i++) shift_px(6'($urandom));
        do_latch(ra, 1'b1);
        tick(7);
        do_latch(rb, 1'b1);
        chk_status(1'b1);
        tick(80);
        chk_row(rb);
        clear_flags();

        // Reset mid-copy
        random_row(int'($urandom_range(0, NRows - 1)), 1'b0);
        tick(20);
        pulse_reset();
        chk_status(1'b0);
        random_row(int'($urandom_range(0, NRows - 1)), 1'b1);
        tick(80);
        chk_row(m_last_row);
        chk_status(1'b0);

`ifdef HUB75_CAPTURE_STATS_EN
        bus_access(StatsA, 1'b1, 32'd0, 4'hF, 1'b1, d);
        m_latches = 0; m_frames = 0;
`endif
        // Two full panel frames
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < NRows; r++) random_row(r, 1'($urandom));
        tick(80);
        chk_row(0);
        chk_row(NRows - 1);
        chk_row(int'($urandom_range(1, NRows - 2)));
        chk_status(1'b0);
`ifdef HUB75_CAPTURE_STATS_EN
        bus_read(StatsA, d);
        chk("stats", d, {16'(m_frames), 16'(m_latches)});
`else
        bus.addr = StatsA; #1;
        chk("active_stats", {31'b0, bus.active}, 32'd0);
        bus_access(StatsA, 1'b0, 32'd0, 4'h0, 1'b0, d);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/hub75_capture.md
HUB75_CAPTURE -- requirements
Module: hub75_capture

Interface
REQ-001 SHALL have parameter ROWS, default 64, meaning total panel rows; the panel exposes ROWS/2 row addresses.
REQ-002 SHALL have parameter COLS, default 64, meaning the number of pixels shifted per row.
REQ-003 SHALL have parameter BASEADDR, default 32'h82000000, meaning the bus byte base address.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; every flop is clocked on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have ports addr, wdata and wmask, inputs of 32, 32 and 4 bits: bus byte address, write data and byte enables.
REQ-007 SHALL have ports wen and ren, inputs of 1 bit each: bus write strobe and read strobe.
REQ-008 SHALL have ports rdata (output, 32 bits, registered read data) and ready (output, 1 bit, access complete).
REQ-009 SHALL have port active, output, 1 bit: combinational decode, true when addr lies in [BASEADDR, BASEADDR+4*(ROWS/2*COLS+1)).
REQ-010 SHALL have ports R0, G0, B0, R1, G1, B1, inputs of 1 bit each: HUB75 upper-half and lower-half colour data.
REQ-011 SHALL have port ROWSEL, input, $clog2(ROWS/2) bits: HUB75 row address.
REQ-012 SHALL have ports CLK_HUB75 and LATCH (latch on rising edge) and OE (active-low), inputs of 1 bit each.

Function
REQ-013 SHALL pass all HUB75 inputs through the same 2-flop synchronizer; edges SHALL be detected on the synchronized copies.
REQ-014 On a CLK_HUB75 rising edge, SHALL write the pixel {B1,G1,R1,B0,G0,R0} into the fill line bank at index col_cnt, then increment col_cnt.
REQ-015 When col_cnt==COLS, SHALL discard further shift edges, hold col_cnt, and set sticky status bit LONG.
REQ-016 On a LATCH rising edge, SHALL: capture ROWSEL, col_cnt and ~OE; swap the fill and copy banks; reset col_cnt to 0; start the copy FSM.
REQ-017 If a CLK_HUB75 rising edge and a LATCH rising edge occur in the same cycle, SHALL store the pixel in the old bank before the swap.
REQ-018 SHALL set sticky status bit SHORT when col_cnt<COLS at a latch edge.
REQ-019 Copy FSM states and transitions:
  - IDLE: goes to COPY on a latch edge.
  - COPY: writes one entry per cycle into frame RAM at {row, idx}, idx 0..COLS-1.
  - COPY returns to IDLE after idx==COLS-1, so a copy takes exactly COLS cycles.
REQ-020 On a latch edge while in COPY, SHALL abort the current copy, set sticky bit OVERRUN, and restart COPY with the new bank and row.
REQ-021 Frame RAM SHALL be ROWS/2*COLS entries of 6 bits, with a dedicated write port (copy) and a dedicated read port (bus).
REQ-022 A bus read of word w < ROWS/2*COLS SHALL return {26'b0, frame[w]}; bus writes to this range SHALL be ignored.
REQ-023 A bus read of word ROWS/2*COLS (the status register) SHALL return:
  - [7:0] col_cnt at last latch
  - [15:8] last latched row
  - [16] SHORT
  - [17] LONG
  - [18] OVERRUN
  - [19] OE-asserted at last latch
  - [20] copy busy
REQ-024 Writing 1 to status bits [18:16] with wmask[2] set SHALL clear those bits; a clear in the same cycle as a set SHALL lose to the set.
REQ-025 When active and (ren|wen), SHALL drive rdata and assert ready on the next cycle; ready SHALL be 0 in every other cycle.

Reset
REQ-026 When rst_n==0 at a clk edge, the following SHALL become 0: ready, rdata, col_cnt, bank select, copy FSM (IDLE), all status fields, and synchronizer/edge history.
REQ-027 Frame RAM contents SHALL NOT be cleared by reset.
REQ-028 A reset during COPY SHALL abandon the row, leaving any partly written entries in frame RAM.

Configuration
REQ-029 With macro HUB75_CAPTURE_STATS_EN defined, SHALL add word ROWS/2*COLS+1 as a stats register, and decode active over one extra word.
  - [15:0] latch count, 16-bit, wrapping.
  - [31:16] frame count: increments on each latch with row==ROWS/2-1, 16-bit, wrapping.
  - Any write clears both counts.
  - Reset zeroes both counts.
REQ-030 Without HUB75_CAPTURE_STATS_EN, SHALL have no counters, and that address SHALL be outside the active decode.

Verification
REQ-031 Sequence: shift 64 pixels, pixel i = i[5:0]; then latch with ROWSEL=5 -> after 64+4 cycles, read word 5*64+i returns i[5:0]; status = 64 / row 5, no flags.
REQ-032 Sequence: 40 shift edges, then latch -> status[7:0]=40, SHORT=1; then write 32'h00070000 -> SHORT=0.
REQ-033 Sequence: 70 shift edges, then latch -> LONG=1; entries 0..63 hold the first 64 pixels.
REQ-034 Sequence: two latches 10 cycles apart -> OVERRUN=1, and the second row is fully written into frame RAM.
REQ-035 Sequence: drive the panel-driver waveform (3-cycle pixel period, 32 rows) for 2 frames with STATS_EN defined -> latch count 64, frame count 2.
REQ-036 Sequence: rst_n=0 for one cycle mid-COPY -> status reads 0, col_cnt=0, and the next full row captures correctly.
